scan_doubler: RTL

SCAN_DOUBLER -- requirements
Module: scan_doubler

---
 rtl/tankb_video_pkg.sv | 25 ++
 rtl/line_buf_dp.sv | 28 ++
 rtl/scan_doubler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/tankb_video_pkg.sv
// Shared video constants and pixel types for the tank-battle
// video path: line-buffer sizing, sync width and colour levels.
package tankb_video_pkg;

  localparam int ADDR_W_DEF   = 9;
  localparam int HS_WIDTH_DEF = 46;

  localparam logic [5:0] LVL_FULL = 6'h3F;
  localparam logic [5:0] LVL_HALF = 6'h2A;

  typedef struct packed {
    logic       blank;
    logic [3:0] rgb;
  } pix_t;

  function automatic logic [5:0] lvl(
    input logic on,
    input logic bright
  );
    if (!on)
      return 6'h00;
    return bright ? LVL_FULL : LVL_HALF;
  endfunction

endpackage

// File: rtl/line_buf_dp.sv
// Simple dual-port line buffer: one write port, one registered
// read port; contents are never cleared.
module line_buf_dp #(
  parameter int AW = 10,
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i)
      mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (re_i)
      rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/scan_doubler.sv
// Line-doubling scan converter: stores each native line in a
// ping-pong buffer and replays it twice at the doubled pixel rate.
module scan_doubler
  import tankb_video_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int HS_WIDTH = HS_WIDTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce_pix,
  input  logic       ce_pix2x,
  input  logic [3:0] in_rgb,
  input  logic       in_blank,
  input  logic       in_hs_n,
  input  logic       in_vs_n,
  output logic [5:0] VGA_R,
  output logic [5:0] VGA_G,
  output logic [5:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS
);

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] CNT_ONE = 1;
  localparam logic [ADDR_W:0]   LEN_ONE = 1;
  localparam logic [ADDR_W:0]   HS_END  = (ADDR_W+1)'(HS_WIDTH);

  logic              hs_prev_q, vs_in_q;
  logic              armed_q, locked_q, wr_bank_q;
  logic [ADDR_W-1:0] wr_cnt_q, rd_cnt_q;
  logic [ADDR_W:0]   line_len_q;
  logic              s1_valid_q, s1_hs_q;
  logic              s1_sol_q, s1_vs_q;

  logic              line_start, wr_sat, we, rd_wrap;
  logic              wr_bank_d;
  logic [ADDR_W-1:0] wr_cnt_d, rd_cnt_d;
  logic [4:0]        rd_data;
  pix_t              rd_pix, wr_pix;
  logic [5:0]        r_d, g_d, b_d;
  logic              hs_d, vs_d;

  assign line_start = ce_pix & hs_prev_q & ~in_hs_n;
  assign wr_sat     = (wr_cnt_q == CNT_MAX);
  assign wr_bank_d  = wr_bank_q ^ line_start;
  assign we         = ~rst & ce_pix & (line_start | ~wr_sat);
  assign rd_wrap    = ({1'b0, rd_cnt_q} == line_len_q - LEN_ONE);
  assign wr_pix     = '{blank: in_blank, rgb: in_rgb};
  assign rd_pix     = rd_data;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (line_start)
      wr_cnt_d = '0;
    else if (!wr_sat)
      wr_cnt_d = wr_cnt_q + CNT_ONE;
  end

  // Resync at line start takes precedence over the wrap point.
  always_comb begin
    rd_cnt_d = rd_cnt_q + CNT_ONE;
    if (!locked_q || line_start || rd_wrap)
      rd_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_prev_q  <= 1'b0;
      vs_in_q    <= 1'b1;
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      line_len_q <= '0;
      armed_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else if (ce_pix) begin
      hs_prev_q <= in_hs_n;
      vs_in_q   <= in_vs_n;
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      if (line_start) begin
        line_len_q <= {1'b0, wr_cnt_q} + LEN_ONE;
        locked_q   <= armed_q;
        armed_q    <= 1'b1;
      end
    end
  end

  line_buf_dp #(
    .AW(ADDR_W + 1),
    .DW(5)
  ) u_buf (
    .clk    (clk),
    .we_i   (we),
    .waddr_i({wr_bank_d, wr_cnt_d}),
    .wdata_i(wr_pix),
    .re_i   (ce_pix2x),
    .raddr_i({~wr_bank_q, rd_cnt_q}),
    .rdata_o(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_hs_q    <= 1'b0;
      s1_sol_q   <= 1'b0;
      s1_vs_q    <= 1'b1;
    end else if (ce_pix2x) begin
      rd_cnt_q   <= rd_cnt_d;
      s1_valid_q <= locked_q;
      s1_hs_q    <= ({1'b0, rd_cnt_q} < HS_END);
      s1_sol_q   <= (rd_cnt_q == '0);
      s1_vs_q    <= vs_in_q;
    end
  end

  always_comb begin
    r_d  = '0;
    g_d  = '0;
    b_d  = '0;
    hs_d = 1'b1;
    vs_d = 1'b1;
    if (s1_valid_q) begin
      hs_d = ~s1_hs_q;
      vs_d = s1_sol_q ? s1_vs_q : VGA_VS;
      if (!rd_pix.blank) begin
        r_d = lvl(rd_pix.rgb[1], rd_pix.rgb[0]);
        g_d = lvl(rd_pix.rgb[2], rd_pix.rgb[0]);
        b_d = lvl(rd_pix.rgb[3], rd_pix.rgb[0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else if (ce_pix2x) begin
      VGA_R  <= r_d;
      VGA_G  <= g_d;
      VGA_B  <= b_d;
      VGA_HS <= hs_d;
      VGA_VS <= vs_d;
    end
  end

endmodule
